// File: rtl/mix_output_stage.sv
// Mixer-to-codec output stage.
// Samples the 10-bit mixer sum once per sample tick, re-centres it to signed
// PCM, applies a volume shift with saturation, buffers the result in a small
// FIFO and hands samples to the codec with a one-cycle write strobe.
module mix_output_stage #(
    parameter int SAMPLE_DIV = 1042,
    parameter int SHIFT_BASE = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [31:0] mix_down,
    input  logic [2:0]  volume,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic [2:0]  fifo_level,
    output logic        overflow
);

    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WIDE_W = 43;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [10:0]      CENTRE   = 11'd510;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Widen, shift by base+volume, and clamp into signed 32-bit range.
    function automatic logic [31:0] scale_sat(input logic signed [10:0] c,
                                              input logic [2:0] vol);
        logic signed [WIDE_W-1:0] wide;
        logic [31:0]              res;
        wide = {{(WIDE_W-11){c[10]}}, c};
        wide = wide <<< (SHIFT_BASE + int'(vol));
        if (!wide[WIDE_W-1] && (|wide[WIDE_W-2:31])) begin
            res = 32'h7FFF_FFFF;
        end else if (wide[WIDE_W-1] && !(&wide[WIDE_W-2:31])) begin
            res = 32'h8000_0000;
        end else begin
            res = wide[31:0];
        end
        return res;
    endfunction

    // Upper mixer bits carry no audio information.
    logic unused_mix_hi_s;
    assign unused_mix_hi_s = ^mix_down[31:10];

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tick_s;
    logic signed [10:0]      c_q, c_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [31:0]             s2_data_q, s2_data_d;
    logic                    s2_valid_q, s2_valid_d;

    logic [31:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    overflow_q;
    logic                    full_s, pop_s, push_ok_s, drop_s;

    state_t                  state_q;
    logic                    write_q;
    logic [31:0]             left_q, right_q;

    // Tick counter and two-stage sample pipeline next-state logic.
    always_comb begin
        cnt_d      = cnt_q;
        c_d        = c_q;
        s2_data_d  = s2_data_q;
        tick_s     = enable && (cnt_q == CNT_LAST);
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (tick_s) begin
            c_d = {1'b0, mix_down[9:0]} - CENTRE;
        end else begin
            c_d = c_q;
        end
        s1_valid_d = tick_s;
        if (s1_valid_q) begin
            s2_data_d = scale_sat(c_q, volume);
        end else begin
            s2_data_d = s2_data_q;
        end
        s2_valid_d = s1_valid_q;
    end

    // Registers for the tick counter and sample pipeline.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            c_q        <= '0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            s1_valid_q <= s1_valid_d;
            s2_data_q  <= s2_data_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // FIFO control: a pop frees a slot in the same cycle a push arrives.
    always_comb begin
        full_s    = (level_q == LVL_FULL);
        pop_s     = (state_q == ST_IDLE) && (level_q != '0) && audio_out_allowed;
        push_ok_s = s2_valid_q && (!full_s || pop_s);
        drop_s    = s2_valid_q && full_s && !pop_s;
        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage, circular pointers, level and sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= s2_data_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Codec handshake FSM: load head and pop in IDLE, strobe in WRITE, rest in GAP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        left_q  <= mem_q[rd_ptr_q];
                        right_q <= mem_q[rd_ptr_q];
                        write_q <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        write_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    write_q <= 1'b0;
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    write_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    write_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign write_audio_out         = write_q;
    assign left_channel_audio_out  = left_q;
    assign right_channel_audio_out = right_q;
    assign fifo_level              = 3'(level_q);
    assign overflow                = overflow_q;

endmodule

// File: tb/tb_mix_output_stage.sv
// Directed testbench for mix_output_stage with SAMPLE_DIV=8.
module tb_mix_output_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [31:0] mix_down;
    logic [2:0]  volume;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [2:0]  fifo_level;
    logic        overflow;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [31:0] wdata [8];
    int          widx  [8];
    int          nw;

    mix_output_stage #(
        .SAMPLE_DIV(8),
        .SHIFT_BASE(18),
        .FIFO_DEPTH(4)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .enable                 (enable),
        .mix_down               (mix_down),
        .volume                 (volume),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .fifo_level             (fifo_level),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with enable low: one tick, then check the resulting write.
    task automatic do_sample(input string tag, input logic [31:0] mix,
                             input logic [2:0] vol, input logic [31:0] exp);
        int          first_i;
        int          width;
        logic [31:0] dl;
        logic [31:0] dr;
        first_i  = -1;
        width    = 0;
        dl       = 32'hDEAD_BEEF;
        dr       = 32'hDEAD_BEEF;
        mix_down = mix;
        volume   = vol;
        enable   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (write_audio_out) begin
                width = width + 1;
                if (first_i < 0) begin
                    first_i = i;
                    dl = left_channel_audio_out;
                    dr = right_channel_audio_out;
                end
            end
            if (i == 8) enable = 1'b0;
        end
        chk({tag, " latency"}, 32'(first_i), 32'd10);
        chk({tag, " strobe_len"}, 32'(width), 32'd1);
        chk({tag, " left"}, dl, exp);
        chk({tag, " right"}, dr, exp);
    endtask

    // Called at a negedge: record write strobes over a window.
    task automatic capture(input int cycles);
        nw = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (write_audio_out) begin
                if (nw < 8) begin
                    wdata[nw] = left_channel_audio_out;
                    widx[nw]  = i;
                end
                nw = nw + 1;
            end
        end
    endtask

    initial begin
        int strobes;
        resetn            = 1'b0;
        enable            = 1'b0;
        mix_down          = 32'd1020;
        volume            = 3'd0;
        audio_out_allowed = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst write", 32'(write_audio_out), 32'd0);
        chk("rst left", left_channel_audio_out, 32'd0);
        chk("rst right", right_channel_audio_out, 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);

        // Idle with enable low: no strobes
        resetn            = 1'b1;
        audio_out_allowed = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (write_audio_out) strobes = strobes + 1;
        end
        chk("idle strobes", 32'(strobes), 32'd0);
        chk("idle level", 32'(fifo_level), 32'd0);

        // Centring and saturation
        do_sample("mid510", 32'd510, 3'd0, 32'h0000_0000);
        do_sample("max1020", 32'd1020, 3'd0, 32'h07F8_0000);
        do_sample("min0", 32'd0, 3'd0, 32'hF808_0000);
        do_sample("upperbits", 32'hFFFF_FDFE, 3'd0, 32'h0000_0000);
        do_sample("vol4", 32'd1020, 3'd4, 32'h7F80_0000);
        do_sample("vol5sat", 32'd1020, 3'd5, 32'h7FFF_FFFF);
        do_sample("vol7neg", 32'd0, 3'd7, 32'h8000_0000);
        volume = 3'd0;

        // Backpressure / overflow: 6 ticks into a 4-deep FIFO
        audio_out_allowed = 1'b0;
        mix_down          = 32'd520;
        enable            = 1'b1;
        for (int i = 0; i < 56; i++) begin
            @(negedge clk);
            if ((i % 8) == 0 && i < 48) mix_down = 32'(520 + 10 * (i / 8));
            if (i == 48) enable = 1'b0;
        end
        chk("bp level", 32'(fifo_level), 32'd4);
        chk("bp overflow", 32'(overflow), 32'd1);
        audio_out_allowed = 1'b1;
        capture(20);
        chk("bp nwrites", 32'(nw), 32'd4);
        chk("bp w0", wdata[0], 32'h0028_0000);
        chk("bp w1", wdata[1], 32'h0050_0000);
        chk("bp w2", wdata[2], 32'h0078_0000);
        chk("bp w3", wdata[3], 32'h00A0_0000);
        chk("bp first", 32'(widx[0]), 32'd0);
        chk("bp gap01", 32'(widx[1] - widx[0]), 32'd3);
        chk("bp gap12", 32'(widx[2] - widx[1]), 32'd3);
        chk("bp gap23", 32'(widx[3] - widx[2]), 32'd3);
        chk("bp drained", 32'(fifo_level), 32'd0);
        chk("bp overflow sticky", 32'(overflow), 32'd1);

        // Reset clears the sticky flag
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst2 overflow", 32'(overflow), 32'd0);

        // Full FIFO with a push coinciding with the IDLE pop
        audio_out_allowed = 1'b0;
        mix_down          = 32'd511;
        enable            = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 39) chk("full pre", 32'(fifo_level), 32'd4);
            if (i == 40) begin
                chk("full pre2", 32'(fifo_level), 32'd4);
                enable            = 1'b0;
                audio_out_allowed = 1'b1;
            end
            if (i == 41) begin
                chk("full write", 32'(write_audio_out), 32'd1);
                chk("full head", left_channel_audio_out, 32'h0004_0000);
                chk("full level kept", 32'(fifo_level), 32'd4);
                audio_out_allowed = 1'b0;
            end
            if ((i % 8) == 0 && i < 40) mix_down = 32'(511 + i / 8);
        end
        chk("full overflow", 32'(overflow), 32'd0);
        chk("full level", 32'(fifo_level), 32'd4);
        audio_out_allowed = 1'b1;
        capture(20);
        chk("full nwrites", 32'(nw), 32'd4);
        chk("full w0", wdata[0], 32'h0008_0000);
        chk("full w1", wdata[1], 32'h000C_0000);
        chk("full w2", wdata[2], 32'h0010_0000);
        chk("full w3", wdata[3], 32'h0014_0000);

        // Async reset during a WRITE cycle
        audio_out_allowed = 1'b0;
        mix_down          = 32'd1020;
        enable            = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i == 16) enable = 1'b0;
            if (i == 17) chk("ar level", 32'(fifo_level), 32'd2);
            if (i == 19) audio_out_allowed = 1'b1;
            if (i == 20) begin
                chk("ar in write", 32'(write_audio_out), 32'd1);
                resetn = 1'b0;
                #1;
                chk("ar strobe drop", 32'(write_audio_out), 32'd0);
                chk("ar level clr", 32'(fifo_level), 32'd0);
                chk("ar left clr", left_channel_audio_out, 32'd0);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        do_sample("post_reset", 32'd1020, 3'd0, 32'h07F8_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
